// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers matrices A and B row by row and streams them diagonally skewed into an N x N systolic array
module systolic_feeder #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int ROW_WIDTH  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic                    load_sel,
    input  logic [ROW_WIDTH-1:0]    load_row,
    input  logic [N*DATA_WIDTH-1:0] load_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    pe_enable,
    output logic [N*DATA_WIDTH-1:0] array_in_a_flat,
    output logic [N*DATA_WIDTH-1:0] array_in_b_flat
);
    localparam int RW = $clog2(N);
    localparam logic [CNT_WIDTH-1:0] T_LAST = CNT_WIDTH'(3 * N - 3);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                       state, state_nxt;
    logic [CNT_WIDTH-1:0]         t;
    logic signed [DATA_WIDTH-1:0] a_buf [N][N];
    logic signed [DATA_WIDTH-1:0] b_buf [N][N];
    logic [RW-1:0]                row_idx;

    assign row_idx = load_row[RW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            t     <= '0;
        end else begin
            state <= state_nxt;
            t     <= state == STREAM ? t + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt  = state == IDLE   ? (start ? STREAM : IDLE) :
                     state == STREAM ? (t == T_LAST ? DONE : STREAM) : IDLE;
        load_ready = state == IDLE;
        busy       = state != IDLE;
        done       = state == DONE;
        pe_enable  = state == STREAM;
    end

    // Rows beyond N are dropped; the upper load_row bits only qualify the write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_buf <= '{default: '0};
            b_buf <= '{default: '0};
        end else if (load_valid && load_ready && int'(load_row) < N) begin
            for (int c = 0; c < N; c++) begin
                if (load_sel) b_buf[row_idx][c] <= load_data[c*DATA_WIDTH +: DATA_WIDTH];
                else          a_buf[row_idx][c] <= load_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Slot i carries element k = t - i: A[i][k] on the a side, B[k][i] on the b side.
    always_comb begin
        array_in_a_flat = '0;
        array_in_b_flat = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (state == STREAM && int'(t) == i + k) begin
                    array_in_a_flat[i*DATA_WIDTH +: DATA_WIDTH] = a_buf[i][k];
                    array_in_b_flat[i*DATA_WIDTH +: DATA_WIDTH] = b_buf[k][i];
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: randomized and directed checks of systolic_feeder (N=4 and N=2) against a matrix-level model
module tb_systolic_feeder;
    localparam int DW = 16;

    logic        clk = 0, reset = 0, sel = 0;
    logic        load_valid = 0, load_sel = 0, start = 0;
    logic [2:0]  load_row = '0;
    logic [63:0] load_data = '0;
    logic        lr4, busy4, done4, pe4, lr2, busy2, done2, pe2;
    logic [63:0] a4, b4;
    logic [31:0] a2, b2;
    logic        lr, busy, done, pe;
    logic [63:0] ao, bo;
    int          total = 0, bad = 0;
    int          ma [4][4];
    int          mb [4][4];

    always #5 clk = ~clk;

    systolic_feeder #(.N(4), .ROW_WIDTH(3)) dut4 (
        .clk(clk), .reset(reset), .load_valid(load_valid && !sel), .load_ready(lr4),
        .load_sel(load_sel), .load_row(load_row), .load_data(load_data), .start(start && !sel),
        .busy(busy4), .done(done4), .pe_enable(pe4), .array_in_a_flat(a4), .array_in_b_flat(b4));

    systolic_feeder #(.N(2), .ROW_WIDTH(1)) dut2 (
        .clk(clk), .reset(reset), .load_valid(load_valid && sel), .load_ready(lr2),
        .load_sel(load_sel), .load_row(load_row[0]), .load_data(load_data[31:0]), .start(start && sel),
        .busy(busy2), .done(done2), .pe_enable(pe2), .array_in_a_flat(a2), .array_in_b_flat(b2));

    assign lr   = sel ? lr2 : lr4;
    assign busy = sel ? busy2 : busy4;
    assign done = sel ? done2 : done4;
    assign pe   = sel ? pe2 : pe4;
    assign ao   = sel ? {32'b0, a2} : a4;
    assign bo   = sel ? {32'b0, b2} : b4;

    function automatic int nn();
        return sel ? 2 : 4;
    endfunction

    function automatic int rnd16();
        logic signed [15:0] v;
        v = 16'($urandom);
        return int'(v);
    endfunction

    task automatic rand_mats();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = rnd16();
                mb[i][j] = rnd16();
            end
    endtask

    task automatic load_mats();
        for (int m = 0; m < 2; m++)
            for (int r = 0; r < nn(); r++) begin
                load_valid = 1;
                load_sel   = 1'(m);
                load_row   = 3'(r);
                for (int c = 0; c < 4; c++) load_data[c*DW +: DW] = DW'(m == 1 ? mb[r][c] : ma[r][c]);
                @(posedge clk); #1;
            end
        load_valid = 0;
    endtask

    // Starts a run, checks every cycle against the skew rule, then replays the
    // streamed slots through an ideal array (A[i][k], B[k][j] meet at k+i+j).
    task automatic run_stream(input bit mid_start, input bit mid_load);
        int     n, t, ea, eb, pe_cnt, done_cnt, done_at;
        int     ga [4];
        int     gb [4];
        int     ha [12][4];
        int     hb [12][4];
        longint cc, gold;
        n = nn(); pe_cnt = 0; done_cnt = 0; done_at = -1;
        ha = '{default: 0};
        hb = '{default: 0};
        start = 1;
        @(posedge clk); #1;
        start = 0; load_valid = 0;
        for (int c = 1; c <= 3 * n + 3; c++) begin
            t = c - 1;
            if (pe) begin
                pe_cnt++;
                for (int i = 0; i < n; i++) begin
                    ga[i] = int'($signed(ao[i*DW +: DW]));
                    gb[i] = int'($signed(bo[i*DW +: DW]));
                    ea = (t - i >= 0 && t - i < n) ? ma[i][t-i] : 0;
                    eb = (t - i >= 0 && t - i < n) ? mb[t-i][i] : 0;
                    total += 2;
                    if (ga[i] !== ea) begin bad++; $display("FAIL stream_a n=%0d t=%0d slot=%0d got=%0d exp=%0d", n, t, i, ga[i], ea); end
                    if (gb[i] !== eb) begin bad++; $display("FAIL stream_b n=%0d t=%0d slot=%0d got=%0d exp=%0d", n, t, i, gb[i], eb); end
                    if (t < 12) begin ha[t][i] = ga[i]; hb[t][i] = gb[i]; end
                end
            end
            if (done) begin done_cnt++; done_at = c; end
            total++;
            if (busy !== (c <= 3 * n - 1) || lr !== (c > 3 * n - 1)) begin
                bad++; $display("FAIL busy_ready n=%0d cycle=%0d busy=%b ready=%b", n, c, busy, lr);
            end
            if (mid_start && (t == 2 || t == 7) && c <= 3 * n - 1) start = 1;
            if (mid_load && c <= 3 * n - 1) begin
                load_valid = 1; load_sel = 1'($urandom); load_row = 3'($urandom_range(0, 3));
                load_data = {$urandom, $urandom};
            end
            @(posedge clk); #1;
            start = 0; load_valid = 0;
        end
        total += 3;
        if (pe_cnt != 3 * n - 2) begin bad++; $display("FAIL pe_cycles n=%0d got=%0d exp=%0d", n, pe_cnt, 3 * n - 2); end
        if (done_cnt != 1) begin bad++; $display("FAIL done_count n=%0d got=%0d exp=1", n, done_cnt); end
        if (done_at != 3 * n - 1) begin bad++; $display("FAIL done_cycle n=%0d got=%0d exp=%0d", n, done_at, 3 * n - 1); end
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                cc = 0; gold = 0;
                for (int tp = 0; tp <= 3 * n - 3; tp++)
                    if (tp - j >= 0 && tp - i >= 0) cc += longint'(ha[tp-j][i]) * longint'(hb[tp-i][j]);
                for (int k = 0; k < n; k++) gold += longint'(ma[i][k]) * longint'(mb[k][j]);
                total++;
                if (cc !== gold) begin bad++; $display("FAIL product n=%0d C[%0d][%0d] got=%0d exp=%0d", n, i, j, cc, gold); end
            end
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (3) begin
            load_valid = 1'($urandom); start = 1'($urandom); load_sel = 1'($urandom);
            load_row = 3'($urandom); load_data = {$urandom, $urandom};
            @(posedge clk); #1;
            for (int s = 0; s < 2; s++) begin
                sel = 1'(s); #1;
                total++;
                if ({lr, busy, done, pe, ao, bo} !== {1'b1, 3'b0, 128'b0}) begin
                    bad++; $display("FAIL reset_state n=%0d ready=%b busy=%b done=%b pe=%b a=%h b=%h", nn(), lr, busy, done, pe, ao, bo);
                end
            end
        end
        load_valid = 0; start = 0; sel = 0; reset = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_identity_ramp();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = (i == j) ? 1 : 0;
                mb[i][j] = 4 * i + j + 1;
            end
        load_mats();
        run_stream(0, 0);
    endtask

    task automatic test_signed_product();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = i - j;
                mb[i][j] = -(i + 1) * (j + 1);
            end
        load_mats();
        run_stream(0, 0);
    endtask

    task automatic test_random();
        repeat (3) begin
            rand_mats();
            load_mats();
            run_stream(0, 0);
        end
    endtask

    task automatic test_protocol();
        rand_mats();
        load_mats();
        run_stream(1, 1);
        run_stream(0, 0);
        load_valid = 1; load_sel = 0; load_row = 3'd5; load_data = {$urandom, $urandom};
        @(posedge clk); #1;
        load_sel = 1; load_row = 3'd7;
        @(posedge clk); #1;
        load_valid = 0;
        run_stream(0, 0);
    endtask

    task automatic test_simultaneous();
        load_valid = 1; load_sel = 0; load_row = 3'd0;
        for (int c = 0; c < 4; c++) begin
            load_data[c*DW +: DW] = 16'd9;
            ma[0][c] = 9;
        end
        run_stream(0, 0);
    endtask

    task automatic test_reset_mid();
        start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int c = 0; c < 4; c++) begin
            total++;
            if (done) begin bad++; $display("FAIL mid_done_pre cycle=%0d got=1 exp=0", c); end
            @(posedge clk); #1;
        end
        reset = 0; #1;
        total++;
        if ({lr, busy, done, pe, ao, bo} !== {1'b1, 3'b0, 128'b0}) begin
            bad++; $display("FAIL mid_reset ready=%b busy=%b done=%b pe=%b a=%h b=%h", lr, busy, done, pe, ao, bo);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++;
            if (done || pe) begin bad++; $display("FAIL mid_reset_hold cycle=%0d done=%b pe=%b exp=0", c, done, pe); end
        end
        reset = 1;
        @(posedge clk); #1;
        ma = '{default: 0};
        mb = '{default: 0};
        run_stream(0, 0);
    endtask

    task automatic test_min_size();
        sel = 1; #1;
        ma = '{default: 0};
        mb = '{default: 0};
        ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
        mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
        load_mats();
        run_stream(0, 0);
        rand_mats();
        load_mats();
        run_stream(1, 1);
        sel = 0; #1;
    endtask

    initial begin
        test_reset();
        test_identity_ramp();
        test_signed_product();
        test_random();
        test_protocol();
        test_simultaneous();
        test_reset_mid();
        test_min_size();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
